// File: rtl/ysyx_22041412_mdu_ctrl.sv
// ---------------------------------------------------------------------------
// ysyx_22041412_mdu_ctrl
//
// Sequencing controller for the RV64M datapath. It accepts one decoded
// mul/div op at a time and stalls the pipeline through `busy`. It issues the
// op to the shared multiplier or divider with the proper signedness and word
// mode. Divide-by-zero and signed overflow are resolved locally. The 64-bit
// result returns over a valid/ready writeback handshake.
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   flush                      pipeline kill, aborts any in-flight op
//   in_valid / in_ready        decoded-op handshake (in_ready = idle)
//   mul_en, div_en             decode class (mul_en has priority)
//   func3, rv64_w, rd          M-extension func3, W variant, destination
//   src1, src2                 operand values
//   mul_valid/ready, mul_sign, mul_a/b                 multiplier issue
//   mul_out_valid, mul_hi/lo                           multiplier result
//   div_valid/ready, div_signed, div_a/b               divider issue
//   div_out_valid, div_quot/rem                        divider result
//   unit_flush                 one-cycle abort pulse to both units
//   out_valid/ready, out_rd, out_data                  writeback handshake
//   busy                       stall request (controller not idle)
// ---------------------------------------------------------------------------
module ysyx_22041412_mdu_ctrl #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            mul_en,
    input  logic            div_en,
    input  logic [2:0]      func3,
    input  logic            rv64_w,
    input  logic [4:0]      rd,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    output logic            mul_valid,
    input  logic            mul_ready,
    output logic [1:0]      mul_sign,
    output logic [XLEN-1:0] mul_a,
    output logic [XLEN-1:0] mul_b,
    input  logic            mul_out_valid,
    input  logic [XLEN-1:0] mul_hi,
    input  logic [XLEN-1:0] mul_lo,
    output logic            div_valid,
    input  logic            div_ready,
    output logic            div_signed,
    output logic [XLEN-1:0] div_a,
    output logic [XLEN-1:0] div_b,
    input  logic            div_out_valid,
    input  logic [XLEN-1:0] div_quot,
    input  logic [XLEN-1:0] div_rem,
    output logic            unit_flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [4:0]      out_rd,
    output logic [XLEN-1:0] out_data,
    output logic            busy
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        MUL_ISSUE = 3'd1,
        MUL_WAIT  = 3'd2,
        DIV_ISSUE = 3'd3,
        DIV_WAIT  = 3'd4,
        DONE      = 3'd5
    } state_e;

    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return {{(XLEN-32){v[31]}}, v};
    endfunction

    function automatic logic [XLEN-1:0] zext32(input logic [31:0] v);
        return {{(XLEN-32){1'b0}}, v};
    endfunction

    state_e          state_q, state_d;
    logic [4:0]      rd_q, rd_d;
    logic            w_q, w_d;
    // Result select: mul -> take low product word; div -> take remainder.
    logic            sel_q, sel_d;
    logic [1:0]      mul_sign_q, mul_sign_d;
    logic [XLEN-1:0] mul_a_q, mul_a_d, mul_b_q, mul_b_d;
    logic            div_signed_q, div_signed_d;
    logic [XLEN-1:0] div_a_q, div_a_d, div_b_q, div_b_d;
    logic [XLEN-1:0] out_data_q, out_data_d;
    logic            unit_flush_q, unit_flush_d;

    // func3[2] is implied by the mul/div class enables.
    logic            unused_func3_hi;
    assign unused_func3_hi = func3[2];

    // Operand preparation for the op currently presented on the inputs.
    logic            accept;
    logic            div_sgn;
    logic [1:0]      mul_sign_prep;
    logic [XLEN-1:0] mul_a_prep, mul_b_prep, div_a_prep, div_b_prep;
    logic            div_by_zero, div_ovf;
    logic [XLEN-1:0] special_raw, special_res;
    logic [XLEN-1:0] mul_res, div_res;

    assign in_ready = (state_q == IDLE) & rst_n;
    assign busy     = (state_q != IDLE) & rst_n;
    assign accept   = in_valid & in_ready & (mul_en | div_en) & ~flush;

    assign div_sgn    = ~func3[0];
    assign mul_a_prep = rv64_w ? sext32(src1[31:0]) : src1;
    assign mul_b_prep = rv64_w ? sext32(src2[31:0]) : src2;
    assign div_a_prep = !rv64_w ? src1 : (div_sgn ? sext32(src1[31:0]) : zext32(src1[31:0]));
    assign div_b_prep = !rv64_w ? src2 : (div_sgn ? sext32(src2[31:0]) : zext32(src2[31:0]));

    always_comb begin
        mul_sign_prep = 2'b00;
        if (rv64_w) begin
            // Only the low 32 product bits survive, so mulw runs signed.
            mul_sign_prep = 2'b11;
        end else begin
            case (func3[1:0])
                2'b01:   mul_sign_prep = 2'b11;
                2'b10:   mul_sign_prep = 2'b10;
                default: mul_sign_prep = 2'b00;
            endcase
        end
    end

    // Overflow is judged at the operating width, not on the extended value.
    assign div_by_zero = (div_b_prep == '0);
    assign div_ovf     = div_sgn & (rv64_w ?
                         ((src1[31:0] == 32'h8000_0000) & (src2[31:0] == 32'hFFFF_FFFF)) :
                         ((src1 == MOST_NEG) & (src2 == ALL_ONES)));

    assign special_raw = func3[1] ? (div_by_zero ? div_a_prep : '0)
                                  : (div_by_zero ? ALL_ONES : div_a_prep);
    assign special_res = rv64_w ? sext32(special_raw[31:0]) : special_raw;

    assign mul_res = w_q ? sext32((sel_q ? mul_lo[31:0] : mul_hi[31:0]))
                         : (sel_q ? mul_lo : mul_hi);
    assign div_res = w_q ? sext32((sel_q ? div_rem[31:0] : div_quot[31:0]))
                         : (sel_q ? div_rem : div_quot);

    always_comb begin
        state_d      = state_q;
        rd_d         = rd_q;
        w_d          = w_q;
        sel_d        = sel_q;
        mul_sign_d   = mul_sign_q;
        mul_a_d      = mul_a_q;
        mul_b_d      = mul_b_q;
        div_signed_d = div_signed_q;
        div_a_d      = div_a_q;
        div_b_d      = div_b_q;
        out_data_d   = out_data_q;
        unit_flush_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    rd_d = rd;
                    w_d  = rv64_w;
                    if (mul_en) begin
                        sel_d      = (func3[1:0] == 2'b00);
                        mul_sign_d = mul_sign_prep;
                        mul_a_d    = mul_a_prep;
                        mul_b_d    = mul_b_prep;
                        state_d    = MUL_ISSUE;
                    end else begin
                        sel_d        = func3[1];
                        div_signed_d = div_sgn;
                        div_a_d      = div_a_prep;
                        div_b_d      = div_b_prep;
                        if (div_by_zero | div_ovf) begin
                            out_data_d = special_res;
                            state_d    = DONE;
                        end else begin
                            state_d = DIV_ISSUE;
                        end
                    end
                end
            end
            MUL_ISSUE: begin
                if (flush) begin
                    state_d      = IDLE;
                    unit_flush_d = 1'b1;
                end else if (mul_ready) begin
                    state_d = MUL_WAIT;
                end
            end
            MUL_WAIT: begin
                if (flush) begin
                    state_d      = IDLE;
                    unit_flush_d = 1'b1;
                end else if (mul_out_valid) begin
                    out_data_d = mul_res;
                    state_d    = DONE;
                end
            end
            DIV_ISSUE: begin
                if (flush) begin
                    state_d      = IDLE;
                    unit_flush_d = 1'b1;
                end else if (div_ready) begin
                    state_d = DIV_WAIT;
                end
            end
            DIV_WAIT: begin
                if (flush) begin
                    state_d      = IDLE;
                    unit_flush_d = 1'b1;
                end else if (div_out_valid) begin
                    out_data_d = div_res;
                    state_d    = DONE;
                end
            end
            DONE: begin
                // A completing handshake takes precedence over a flush.
                if (out_ready | flush) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            rd_q         <= '0;
            w_q          <= 1'b0;
            sel_q        <= 1'b0;
            mul_sign_q   <= '0;
            mul_a_q      <= '0;
            mul_b_q      <= '0;
            div_signed_q <= 1'b0;
            div_a_q      <= '0;
            div_b_q      <= '0;
            out_data_q   <= '0;
            unit_flush_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rd_q         <= rd_d;
            w_q          <= w_d;
            sel_q        <= sel_d;
            mul_sign_q   <= mul_sign_d;
            mul_a_q      <= mul_a_d;
            mul_b_q      <= mul_b_d;
            div_signed_q <= div_signed_d;
            div_a_q      <= div_a_d;
            div_b_q      <= div_b_d;
            out_data_q   <= out_data_d;
            unit_flush_q <= unit_flush_d;
        end
    end

    assign mul_valid  = (state_q == MUL_ISSUE);
    assign div_valid  = (state_q == DIV_ISSUE);
    assign out_valid  = (state_q == DONE);
    assign mul_sign   = mul_sign_q;
    assign mul_a      = mul_a_q;
    assign mul_b      = mul_b_q;
    assign div_signed = div_signed_q;
    assign div_a      = div_a_q;
    assign div_b      = div_b_q;
    assign unit_flush = unit_flush_q;
    assign out_rd     = rd_q;
    assign out_data   = out_data_q;

endmodule

// File: tb/tb_ysyx_22041412_mdu_ctrl.sv
// ---------------------------------------------------------------------------
// Bench for ysyx_22041412_mdu_ctrl. The bench acts as the multiplier and
// divider. It plays directed ops and keeps an ISA-level reference model of
// every expected writeback in a queue. A monitor compares each writeback
// cycle against that queue.
// ---------------------------------------------------------------------------
module tb_ysyx_22041412_mdu_ctrl;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_ready, mul_en, div_en, rv64_w;
    logic [2:0]  func3;
    logic [4:0]  rd, out_rd;
    logic [63:0] src1, src2;
    logic        mul_valid, mul_ready, mul_out_valid;
    logic [1:0]  mul_sign;
    logic [63:0] mul_a, mul_b, mul_hi, mul_lo;
    logic        div_valid, div_ready, div_signed, div_out_valid;
    logic [63:0] div_a, div_b, div_quot, div_rem;
    logic        unit_flush, out_valid, out_ready, busy;
    logic [63:0] out_data;

    always #5 clk = ~clk;

    ysyx_22041412_mdu_ctrl dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .mul_en(mul_en), .div_en(div_en), .func3(func3), .rv64_w(rv64_w),
        .rd(rd), .src1(src1), .src2(src2),
        .mul_valid(mul_valid), .mul_ready(mul_ready), .mul_sign(mul_sign),
        .mul_a(mul_a), .mul_b(mul_b), .mul_out_valid(mul_out_valid),
        .mul_hi(mul_hi), .mul_lo(mul_lo),
        .div_valid(div_valid), .div_ready(div_ready), .div_signed(div_signed),
        .div_a(div_a), .div_b(div_b), .div_out_valid(div_out_valid),
        .div_quot(div_quot), .div_rem(div_rem),
        .unit_flush(unit_flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_rd(out_rd), .out_data(out_data), .busy(busy)
    );

    int n_chk = 0;
    int n_err = 0;

    typedef struct packed {
        logic [4:0]  rd;
        logic [63:0] data;
    } exp_t;
    exp_t exp_q[$];

    // Unit model knobs and observations.
    int          mul_hold = 0, div_hold = 0, mul_lat = 2, div_lat = 3;
    int          mul_hs_cnt = 0, div_hs_cnt = 0;
    logic [1:0]  last_mul_sign = 2'b00;
    logic        last_div_signed = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [127:0] ext128(input logic [63:0] v, input logic s);
        return s ? {{64{v[63]}}, v} : {64'd0, v};
    endfunction

    // RISC-V M-extension result, straight from the instruction semantics.
    function automatic logic [63:0] ref_result(input logic me, input logic [2:0] f3,
                                               input logic w, input logic [63:0] a,
                                               input logic [63:0] b);
        logic [127:0] p;
        logic [31:0]  a32, b32, r32;
        logic [63:0]  r;
        logic         sg, rm;
        a32 = a[31:0];
        b32 = b[31:0];
        if (me) begin
            if (w) begin
                r32 = a32 * b32;
                return {{32{r32[31]}}, r32};
            end
            case (f3[1:0])
                2'b00:   begin p = ext128(a, 1'b0) * ext128(b, 1'b0); return p[63:0]; end
                2'b01:   p = ext128(a, 1'b1) * ext128(b, 1'b1);
                2'b10:   p = ext128(a, 1'b1) * ext128(b, 1'b0);
                default: p = ext128(a, 1'b0) * ext128(b, 1'b0);
            endcase
            return p[127:64];
        end
        sg = !f3[0];
        rm = f3[1];
        if (w) begin
            if (b32 == 32'd0)                                          r32 = rm ? a32 : 32'hFFFF_FFFF;
            else if (sg && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) r32 = rm ? 32'd0 : a32;
            else if (sg) r32 = rm ? $signed(a32) % $signed(b32) : $signed(a32) / $signed(b32);
            else         r32 = rm ? a32 % b32 : a32 / b32;
            return {{32{r32[31]}}, r32};
        end
        if (b == 64'd0)                                                       r = rm ? a : '1;
        else if (sg && a == 64'h8000_0000_0000_0000 && b == '1)                r = rm ? 64'd0 : a;
        else if (sg) r = rm ? $signed(a) % $signed(b) : $signed(a) / $signed(b);
        else         r = rm ? a % b : a / b;
        return r;
    endfunction

    // Multiplier / divider models: ready after a programmable hold, result
    // strobe a programmable number of cycles after the handshake.
    initial begin : units
        int          mvcnt, dvcnt, mcnt, dcnt;
        logic [127:0] mprod;
        logic [63:0]  dq, dr;
        mvcnt = 0; dvcnt = 0; mcnt = 0; dcnt = 0; mprod = '0; dq = '0; dr = '0;
        mul_ready = 0; mul_out_valid = 0; mul_hi = '0; mul_lo = '0;
        div_ready = 0; div_out_valid = 0; div_quot = '0; div_rem = '0;
        forever begin
            @(negedge clk);
            mul_out_valid = 1'b0;
            if (mcnt > 0) begin
                mcnt--;
                if (mcnt == 0) begin
                    mul_out_valid = 1'b1;
                    {mul_hi, mul_lo} = mprod;
                end
            end
            if (mul_valid) begin mul_ready = (mvcnt >= mul_hold); mvcnt++; end
            else begin mul_ready = 1'b0; mvcnt = 0; end
            if (mul_valid && mul_ready) begin
                mprod = ext128(mul_a, mul_sign[1]) * ext128(mul_b, mul_sign[0]);
                last_mul_sign = mul_sign;
                mul_hs_cnt++;
                mcnt = mul_lat;
            end

            div_out_valid = 1'b0;
            if (dcnt > 0) begin
                dcnt--;
                if (dcnt == 0) begin
                    div_out_valid = 1'b1;
                    div_quot = dq;
                    div_rem  = dr;
                end
            end
            if (div_valid) begin div_ready = (dvcnt >= div_hold); dvcnt++; end
            else begin div_ready = 1'b0; dvcnt = 0; end
            if (div_valid && div_ready) begin
                if (div_b == 64'd0) begin dq = '1; dr = div_a; end
                else if (div_signed && div_a == 64'h8000_0000_0000_0000 && div_b == '1) begin
                    dq = div_a; dr = 64'd0;
                end else if (div_signed) begin
                    dq = $signed(div_a) / $signed(div_b);
                    dr = $signed(div_a) % $signed(div_b);
                end else begin
                    dq = div_a / div_b;
                    dr = div_a % div_b;
                end
                last_div_signed = div_signed;
                div_hs_cnt++;
                dcnt = div_lat;
            end
        end
    end

    // Monitor: every cycle, after all drivers have settled.
    initial begin : monitor
        logic        p_ok, p_mv, p_mr, p_ov, p_or;
        logic [63:0] p_ma, p_mb;
        p_ok = 0; p_mv = 0; p_mr = 0; p_ov = 0; p_or = 0; p_ma = '0; p_mb = '0;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n) begin
                chk("in_ready_vs_busy", in_ready, !busy);
                if (p_ok && p_mv && !p_mr) begin
                    chk("mul_valid_hold", mul_valid, 1'b1);
                    chk("mul_a_hold", mul_a, p_ma);
                    chk("mul_b_hold", mul_b, p_mb);
                end
                if (p_ok && p_ov && !p_or) chk("out_valid_hold", out_valid, 1'b1);
                if (out_valid) begin
                    if (exp_q.size() == 0) begin
                        n_chk++;
                        n_err++;
                        $display("FAIL spurious_out_valid: actual out_valid=1 rd=%0d data=%h required no writeback",
                                 out_rd, out_data);
                    end else begin
                        chk("out_data", out_data, exp_q[0].data);
                        chk("out_rd", {59'd0, out_rd}, {59'd0, exp_q[0].rd});
                        if (out_ready) begin
                            $display("writeback rd=%0d data=%h", out_rd, out_data);
                            void'(exp_q.pop_front());
                        end
                    end
                end
            end else begin
                chk("reset_in_ready", in_ready, 1'b0);
                chk("reset_busy", busy, 1'b0);
            end
            p_ok = rst_n && !flush;
            p_mv = mul_valid; p_mr = mul_ready; p_ma = mul_a; p_mb = mul_b;
            p_ov = out_valid; p_or = out_ready;
        end
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic issue(input logic me, input logic de, input logic [2:0] f3, input logic w,
                         input logic [4:0] r, input logic [63:0] a, input logic [63:0] b,
                         input bit push);
        exp_t e;
        int   t;
        t = 0;
        while (!in_ready && t < 100) begin cyc(); t++; end
        chk("issue_in_ready", in_ready, 1'b1);
        if (push) begin
            e.rd   = r;
            e.data = ref_result(me, f3, w, a, b);
            exp_q.push_back(e);
        end
        $display("issue mul_en=%0b div_en=%0b func3=%03b w=%0b rd=%0d src1=%h src2=%h",
                 me, de, f3, w, r, a, b);
        in_valid = 1; mul_en = me; div_en = de; func3 = f3; rv64_w = w; rd = r; src1 = a; src2 = b;
        cyc();
        in_valid = 0; mul_en = 0; div_en = 0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || busy) && t < 300) begin cyc(); t++; end
        chk("wait_idle_timeout", {63'd0, (t >= 300)}, 64'd0);
        exp_q.delete();
    endtask

    typedef struct {
        logic        me, de;
        logic [2:0]  f3;
        logic        w;
        logic [4:0]  rd;
        logic [63:0] a, b, req;
        int          kind;   // 0 multiplier, 1 divider, 2 special case
        logic [1:0]  sgn;
    } vec_t;
    vec_t tbl[17];

    initial begin : main
        int h, n;
        rst_n = 0; flush = 0; in_valid = 0; mul_en = 0; div_en = 0; func3 = '0;
        rv64_w = 0; rd = '0; src1 = '0; src2 = '0; out_ready = 1;

        tbl[0]  = '{1,0,3'b000,0,5'd7, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF1, 0, 2'b00};
        tbl[1]  = '{0,1,3'b101,0,5'd8, 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 2, 2'b00};
        tbl[2]  = '{0,1,3'b111,0,5'd9, 64'h1234, 64'd0, 64'h1234, 2, 2'b00};
        tbl[3]  = '{0,1,3'b100,0,5'd10,64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 2, 2'b00};
        tbl[4]  = '{0,1,3'b110,1,5'd11,64'h8000_0000, 64'hFFFF_FFFF, 64'd0, 2, 2'b00};
        tbl[5]  = '{1,0,3'b000,1,5'd12,64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 0, 2'b11};
        tbl[6]  = '{1,0,3'b001,0,5'd13,64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 64'hFFFF_FFFF_FFFF_FFFF, 0, 2'b11};
        tbl[7]  = '{1,0,3'b010,0,5'd14,64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 0, 2'b10};
        tbl[8]  = '{1,0,3'b011,0,5'd15,64'h8000_0000_0000_0000, 64'd4, 64'd2, 0, 2'b00};
        tbl[9]  = '{0,1,3'b100,0,5'd16,64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1, 2'b01};
        tbl[10] = '{0,1,3'b110,0,5'd17,64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1, 2'b01};
        tbl[11] = '{0,1,3'b101,1,5'd18,64'hFFFF_FFFF_0000_0010, 64'd3, 64'd5, 1, 2'b00};
        tbl[12] = '{0,1,3'b100,1,5'd19,64'h0000_0001_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1, 2'b01};
        tbl[13] = '{0,1,3'b111,1,5'd20,64'h0000_0000_8000_0001, 64'hFFFF_FFFF_0000_0000, 64'hFFFF_FFFF_8000_0001, 2, 2'b00};
        tbl[14] = '{0,1,3'b101,1,5'd21,64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 2, 2'b00};
        tbl[15] = '{0,1,3'b101,0,5'd22,64'hFFFF_FFFF_FFFF_FFFF, 64'h1_0000_0000, 64'h0000_0000_FFFF_FFFF, 1, 2'b00};
        tbl[16] = '{1,1,3'b000,0,5'd23,64'd6, 64'd7, 64'd42, 0, 2'b00};

        // Reset: registered outputs all zero.
        repeat (3) cyc();
        chk("reset_ctrl", {52'd0, mul_valid, div_valid, out_valid, unit_flush, mul_sign, div_signed, out_rd},
            64'd0);
        chk("reset_data", out_data | mul_a | mul_b | div_a | div_b, 64'd0);
        rst_n = 1;
        cyc();
        chk("idle_in_ready", in_ready, 1'b1);

        // Directed vectors.
        foreach (tbl[i]) begin
            chk("model_pin", ref_result(tbl[i].me, tbl[i].f3, tbl[i].w, tbl[i].a, tbl[i].b), tbl[i].req);
            h = div_hs_cnt;
            issue(tbl[i].me, tbl[i].de, tbl[i].f3, tbl[i].w, tbl[i].rd, tbl[i].a, tbl[i].b, 1);
            case (tbl[i].kind)
                0: chk("mul_valid_n1", mul_valid, 1'b1);
                1: chk("div_valid_n1", div_valid, 1'b1);
                default: chk("special_out_valid_n1", out_valid, 1'b1);
            endcase
            wait_idle();
            case (tbl[i].kind)
                0: chk("mul_sign", {62'd0, last_mul_sign}, {62'd0, tbl[i].sgn});
                1: chk("div_signed", {63'd0, last_div_signed}, {63'd0, tbl[i].sgn[0]});
                default: chk("special_no_div_issue", div_hs_cnt, h);
            endcase
        end

        // Decoded op with neither class enable is ignored.
        issue(0, 0, 3'b000, 0, 5'd3, 64'd1, 64'd1, 0);
        chk("no_enable_ignored", busy, 1'b0);

        // Backpressure on both the multiplier and the writeback.
        mul_hold = 5;
        out_ready = 0;
        issue(1, 0, 3'b011, 0, 5'd24, 64'h8000_0000_0000_0000, 64'd4, 1);
        n = 0;
        while (mul_valid && n < 50) begin chk("bp_busy", busy, 1'b1); n++; cyc(); end
        chk("bp_mul_valid_cycles", n, 6);
        n = 0;
        while (!out_valid && n < 50) begin chk("bp_busy", busy, 1'b1); chk("bp_in_ready", in_ready, 1'b0); n++; cyc(); end
        repeat (3) begin
            cyc();
            chk("bp_out_valid", out_valid, 1'b1);
            chk("bp_in_ready", in_ready, 1'b0);
        end
        out_ready = 1;
        cyc();
        chk("bp_released", in_ready, 1'b1);
        mul_hold = 0;
        wait_idle();

        // Flush in DIV_WAIT with a late result strobe.
        div_lat = 6;
        h = div_hs_cnt;
        issue(0, 1, 3'b101, 0, 5'd25, 64'd100, 64'd7, 0);
        n = 0;
        while (div_hs_cnt == h && n < 50) begin cyc(); n++; end
        cyc();
        chk("in_div_wait_busy", busy, 1'b1);
        chk("in_div_wait_div_valid", div_valid, 1'b0);
        flush = 1;
        cyc();
        flush = 0;
        chk("flush_to_idle", busy, 1'b0);
        chk("unit_flush_pulse", unit_flush, 1'b1);
        cyc();
        chk("unit_flush_one_cycle", unit_flush, 1'b0);
        repeat (8) cyc();
        div_lat = 3;
        chk("model_pin_mulhu", ref_result(1, 3'b011, 0, '1, '1), 64'hFFFF_FFFF_FFFF_FFFE);
        issue(1, 0, 3'b011, 0, 5'd26, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        wait_idle();

        // Flush coinciding with the writeback handshake: transaction completes.
        issue(0, 1, 3'b101, 0, 5'd27, 64'h55, 64'd0, 1);
        chk("flush_hs_out_valid", out_valid, 1'b1);
        flush = 1;
        cyc();
        flush = 0;
        chk("flush_hs_idle", busy, 1'b0);
        chk("flush_hs_completed", exp_q.size(), 0);
        chk("flush_hs_no_unit_flush", unit_flush, 1'b0);

        // Reset in the middle of an issue: no unit_flush, back to idle.
        mul_hold = 20;
        issue(1, 0, 3'b000, 0, 5'd28, 64'd9, 64'd9, 0);
        cyc();
        chk("rst_mid_mul_valid", mul_valid, 1'b1);
        rst_n = 0;
        cyc();
        chk("rst_mid_unit_flush", unit_flush, 1'b0);
        chk("rst_mid_mul_valid_low", mul_valid, 1'b0);
        chk("rst_mid_out_valid", out_valid, 1'b0);
        rst_n = 1;
        mul_hold = 0;
        cyc();
        issue(1, 0, 3'b000, 0, 5'd29, 64'd11, 64'd13, 1);
        wait_idle();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/ysyx_22041412_mdu_ctrl.md
# ysyx_22041412_mdu_ctrl

Sequencing controller for the M-extension datapath. It sits between the decode/execute stage and the two iterative arithmetic units: the shared multiplier and the shared divider. It accepts one decoded mul/div operation at a time and stalls the pipeline while busy. It issues the operation to the correct unit with the correct signedness and word mode, and resolves RISC-V divide special cases without using the divider. It then returns a 64-bit writeback result through a valid/ready handshake.

## Interface
- XLEN, 64, operand/result width (only 64 supported)
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset; one clock, reset is synchronous and active-low
- flush  in  1  pipeline kill; aborts any in-flight op
- in_valid  in  1  decoded op presented
- in_ready  out  1  controller idle and able to accept
- mul_en / div_en  in  1 / 1  decode class enables; mul_en wins if both are set
- func3  in  3  M-extension func3
- rv64_w  in  1  W-variant (opcode 0111011): 32-bit op, sign-extended result
- rd  in  5  destination register, carried through
- src1 / src2  in  64 / 64  operand values
- mul_valid / mul_ready  out / in  1 / 1  multiplier issue handshake
- mul_sign  out  2  {src1 signed, src2 signed}
- mul_a / mul_b  out  64 / 64  multiplier operands (registered)
- mul_out_valid  in  1  multiplier result strobe
- mul_hi / mul_lo  in  64 / 64  128-bit product
- div_valid / div_ready  out / in  1 / 1  divider issue handshake
- div_signed  out  1  signed divide
- div_a / div_b  out  64 / 64  dividend / divisor (registered, already W-extended)
- div_out_valid  in  1  divider result strobe
- div_quot / div_rem  in  64 / 64  divider results
- unit_flush  out  1  one-cycle abort pulse to both units
- out_valid / out_ready  out / in  1 / 1  writeback handshake
- out_rd  out  5  destination register
- out_data  out  64  result
- busy  out  1  state != IDLE; used as the stall request

## Operation
- States: IDLE, MUL_ISSUE, MUL_WAIT, DIV_ISSUE, DIV_WAIT, DONE.
- Accept condition: in_valid & in_ready & (mul_en | div_en) & ~flush.
  - On accept, latch rd, func3, rv64_w and the prepared operands.
- Operand preparation for W ops:
  - Signed ops sign-extend src[31:0]; unsigned ops zero-extend src[31:0].
  - mulw always uses the low 32 bits and signed mode.
- Multiplier mode (func3 / mul_sign / result):
  - 000 mul: 00, result mul_lo.
  - 001 mulh: 11, result mul_hi.
  - 010 mulhsu: 10, result mul_hi.
  - 011 mulhu: 00, result mul_hi.
- Divider mode (func3 / div_signed / result):
  - 100 div: signed, result quotient.
  - 101 divu: unsigned, result quotient.
  - 110 rem: signed, result remainder.
  - 111 remu: unsigned, result remainder.
- Divide special cases are detected on accept, bypass the divider, and go straight to DONE:
  - Divisor zero: quotient = all ones; remainder = dividend.
  - Signed overflow (dividend = most-negative, divisor = -1, evaluated at the 32-bit width for W ops): quotient = dividend; remainder = 0.
- W result: out_data = sign-extend(result[31:0]). This applies to every W op, including the special cases (divuw by 0 gives 0xFFFF_FFFF_FFFF_FFFF).
- State transitions:
  - IDLE → MUL_ISSUE or DIV_ISSUE on accept, or IDLE → DONE on a special case.
  - *_ISSUE holds *_valid high with stable operands until *_ready; then → *_WAIT.
  - *_WAIT captures the selected result on *_out_valid; then → DONE.
  - DONE holds out_valid, out_rd and out_data stable until out_ready; then → IDLE.
- Flush from any non-IDLE state: → IDLE on the next edge.
  - unit_flush pulses for one cycle if the state was *_ISSUE or *_WAIT.
  - The result is discarded and no out_valid is produced.
  - A unit strobe arriving after a flush is ignored while IDLE.
- in_valid with neither enable set: ignored, no state change.

## Timing
- Reset (rst_n low at a clock edge): state IDLE.
  - All registered outputs are 0: mul_valid, div_valid, out_valid, unit_flush, out_data, out_rd, mul_a/b, div_a/b, mul_sign, div_signed.
  - in_ready = 0 and busy = 0 while rst_n is low.
- in_ready = (state == IDLE) & rst_n. It is combinational from state.
- Latency (accept at edge N):
  - Special case: out_valid from N+1.
  - Normal op: *_valid from N+1; minimum out_valid = 1 cycle after the *_out_valid capture edge.
- No input bypass: a new op is accepted no earlier than the cycle after the DONE handshake (state IDLE).
- Flush in the same cycle as out_valid & out_ready: the transaction completes; flush has no further effect.
- Flush in the same cycle as *_out_valid: flush wins; the result is dropped.
- Reset mid-operation: behaves as flush, but no unit_flush pulse (the units have their own reset).

## Test plan
- mul: src1=3, src2=-5 (0xFFFF_FFFF_FFFF_FFFB); model returns the product → out_data=0xFFFF_FFFF_FFFF_FFF1, mul_sign=00, out_rd=rd.
- divu by zero: src1=0x1234, src2=0 → out_data=0xFFFF_FFFF_FFFF_FFFF at N+1, div_valid never asserted; same op with func3=111 → 0x1234.
- Overflow: div with src1=0x8000_0000_0000_0000, src2=-1 → out_data=0x8000_0000_0000_0000; remw with src1=0x8000_0000, src2=0xFFFF_FFFF → 0.
- mulw: src1=0x7FFF_FFFF, src2=2, model low 32 bits=0xFFFF_FFFE → out_data=0xFFFF_FFFF_FFFF_FFFE.
- Backpressure: hold mul_ready=0 for 5 cycles, then out_ready=0 for 3 cycles → mul_valid, mul_a, out_valid and out_data stay stable; busy=1 throughout; in_ready=1 only after the out handshake.
- Flush in DIV_WAIT → unit_flush high exactly 1 cycle, next state IDLE, a late div_out_valid produces no out_valid; a following mulhu (src1=src2=2^64-1) returns 0xFFFF_FFFF_FFFF_FFFE.
